ccff_bitstream_loader: RTL

// - Upstream feeder of the IO-tile configuration chain: accepts bitstream words over a

---
 rtl/ccff_bitstream_loader.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/ccff_bitstream_loader.sv
// ccff_bitstream_loader
// Feeds the IO-tile configuration chain. Bitstream words arrive over a
// valid/ready handshake and are shifted MSB-first onto ccff_head, one bit per
// enabled prog_clk. Pads stay isolated (IO_ISOL_N=0) until exactly CHAIN_LEN
// bits have been shifted in; after that, isolation is released.
//
// Ports
//   prog_clk, prog_reset   clock, synchronous active-high reset
//   start                  pulse; honoured only in IDLE/DONE
//   cfg_data/valid/ready   bitstream word handshake
//   ccff_head              serial bit into chain head (registered)
//   ccff_tail              serial bit returning from chain tail
//   prog_clk_en            chain shift enable, high only on valid ccff_head cycles
//   IO_ISOL_N, busy, done  status
//   tail_crc               (CCFF_TAIL_CRC_EN only) CRC-16-CCITT of the tail stream
//
// Optional feature macro: CCFF_TAIL_CRC_EN
module ccff_bitstream_loader #(
  parameter int CHAIN_LEN = 40,
  parameter int WORD_W    = 32
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              prog_clk_en,
  output logic              IO_ISOL_N,
  output logic              busy,
`ifdef CCFF_TAIL_CRC_EN
  output logic [15:0]       tail_crc,
`endif
  output logic              done
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int POS_W = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN);
  localparam logic [POS_W-1:0] LAST_POS = POS_W'(WORD_W);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

  state_t            r_state;
  logic [WORD_W-1:0] r_shift;
  logic [CNT_W-1:0]  r_bit_cnt;  // bits presented so far, including the one on ccff_head
  logic [POS_W-1:0]  r_wpos;     // bits of the current word presented so far
  logic              r_ready, r_head, r_en, r_isol_n, r_busy, r_done;

  logic             w_chain_full, w_word_end, w_load;
  logic [CNT_W-1:0] w_next_cnt;
  logic [POS_W-1:0] w_next_pos;

  assign w_chain_full = (r_bit_cnt == LAST_CNT);
  assign w_word_end   = (r_wpos == LAST_POS);
  assign w_next_cnt   = r_bit_cnt + CNT_W'(1);
  assign w_next_pos   = r_wpos + POS_W'(1);
  // A word is taken either from LOAD or in the last-bit slot of a non-final
  // word; the latter keeps prog_clk_en continuous across word boundaries.
  assign w_load = r_ready & cfg_valid &
                  ((r_state == S_LOAD) ||
                   (r_state == S_SHIFT && !w_chain_full && w_word_end));

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_wpos    <= '0;
      r_ready   <= 1'b0;
      r_head    <= 1'b0;
      r_en      <= 1'b0;
      r_isol_n  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else if (w_load) begin
      // MSB goes straight to the head; the rest waits in the shift register.
      r_state   <= S_SHIFT;
      r_head    <= cfg_data[WORD_W-1];
      r_shift   <= {cfg_data[WORD_W-2:0], 1'b0};
      r_wpos    <= POS_W'(1);
      r_bit_cnt <= w_next_cnt;
      r_en      <= 1'b1;
      r_ready   <= 1'b0;  // WORD_W>=2, so the first bit is never a word's last
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state   <= S_LOAD;
            r_bit_cnt <= '0;
            r_ready   <= 1'b1;
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
            r_isol_n  <= 1'b0;
          end
        end
        S_LOAD: ;  // wait for handshake, outputs already set
        S_SHIFT: begin
          if (w_chain_full) begin
            // Remaining low bits of the final word are dropped here.
            r_state  <= S_DONE;
            r_en     <= 1'b0;
            r_ready  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_isol_n <= 1'b1;
          end else if (w_word_end) begin
            // No word offered in the last-bit slot: bubble, head holds.
            r_state <= S_LOAD;
            r_en    <= 1'b0;
          end else begin
            r_head    <= r_shift[WORD_W-1];
            r_shift   <= {r_shift[WORD_W-2:0], 1'b0};
            r_wpos    <= w_next_pos;
            r_bit_cnt <= w_next_cnt;
            r_ready   <= (w_next_pos == LAST_POS) && (w_next_cnt != LAST_CNT);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cfg_ready   = r_ready;
  assign ccff_head   = r_head;
  assign prog_clk_en = r_en;
  assign IO_ISOL_N   = r_isol_n;
  assign busy        = r_busy;
  assign done        = r_done;

`ifdef CCFF_TAIL_CRC_EN
  // CRC-16-CCITT (0x1021, init 0xFFFF, MSB-first) over the bits leaving the
  // chain tail; it reads back what the previous programming pass loaded.
  logic [15:0] r_crc;
  logic        w_fb, w_start_ok;
  assign w_fb       = r_crc[15] ^ ccff_tail;
  assign w_start_ok = start & ((r_state == S_IDLE) || (r_state == S_DONE));

  always_ff @(posedge prog_clk) begin
    if (prog_reset || w_start_ok) r_crc <= 16'hFFFF;
    else if (r_en)                r_crc <= {r_crc[14:0], 1'b0} ^ (w_fb ? 16'h1021 : 16'h0000);
  end
  assign tail_crc = r_crc;
`else
  logic w_unused_tail;
  assign w_unused_tail = ccff_tail;
`endif

endmodule
